// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the bicycle-computer divider.
//   state_t            - controller states (IDLE, DIVIDE, DONE)
//   DEF_DIVIDEND_WIDTH - default operand width / iteration count
//   DEF_QUOTIENT_WIDTH - default returned quotient width
//   Q_SAT_DEFAULT      - saturated quotient value at the default width
// Optional build macro affecting users of this package: DIVIDER_ROUND_EN.
package div_pkg;

  localparam int unsigned DEF_DIVIDEND_WIDTH = 16;
  localparam int unsigned DEF_QUOTIENT_WIDTH = 12;

  localparam logic [DEF_QUOTIENT_WIDTH-1:0] Q_SAT_DEFAULT = '1;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_t;

endpackage

// File: rtl/div_core.sv
// div_core: restoring-division datapath, one quotient bit per step, MSB first.
// Ports:
//   i_clk, i_rst     - clock, synchronous active-high reset
//   i_load           - latch operands, clear remainder and iteration count
//   i_dividend/i_divisor - operands captured on i_load
//   i_step           - perform one iteration
//   o_last           - current step is the final iteration
//   o_quot_next      - full quotient including the bit produced this step
//   o_round_up       - 2*remainder >= divisor after this step (DIVIDER_ROUND_EN only, else 0)
//   o_div_zero       - latched divisor is zero
// Build macro: DIVIDER_ROUND_EN enables the round-half-up flag.
import div_pkg::*;

module div_core #(
  parameter int unsigned WIDTH = DEF_DIVIDEND_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_step,
  output logic             o_last,
  output logic [WIDTH-1:0] o_quot_next,
  output logic             o_round_up,
  output logic             o_div_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Dividend and quotient share one shift register: dividend bits leave at
  // the MSB while quotient bits enter at the LSB.
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_count;

  // Trial remainder carries the extra bit; the stored remainder is always
  // below the divisor, so it fits in WIDTH bits.
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_next;

  assign w_trial    = {r_rem, r_dq[WIDTH-1]};
  assign w_fits     = w_trial >= {1'b0, r_divisor};
  assign w_rem_next = w_fits ? (w_trial[WIDTH-1:0] - r_divisor) : w_trial[WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dq      <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_count   <= '0;
    end else if (i_load) begin
      r_dq      <= i_dividend;
      r_divisor <= i_divisor;
      r_rem     <= '0;
      r_count   <= '0;
    end else if (i_step) begin
      r_dq      <= {r_dq[WIDTH-2:0], w_fits};
      r_rem     <= w_rem_next;
      r_count   <= r_count + CW'(1);
    end
  end

  assign o_last      = (r_count == CW'(WIDTH - 1));
  assign o_quot_next = {r_dq[WIDTH-2:0], w_fits};
  assign o_div_zero  = (r_divisor == '0);

`ifdef DIVIDER_ROUND_EN
  assign o_round_up = ({w_rem_next, 1'b0} >= {1'b0, r_divisor});
`else
  assign o_round_up = 1'b0;
`endif

endmodule

// File: rtl/shared_divider.sv
// shared_divider: iterative unsigned divider shared by two requesters
// (port 0 = speed, port 1 = average speed) with round-robin arbitration.
// Ports:
//   clock, reset              - clock, synchronous active-high reset
//   req0/dividend0/divisor0   - port 0 request and operands
//   req1/dividend1/divisor1   - port 1 request and operands
//   busy                      - controller not IDLE
//   done0/done1               - one-cycle result-valid pulse per port
//   quotient                  - saturated result, held until next done
//   div_by_zero               - result came from a zero divisor
// Build macro: DIVIDER_ROUND_EN selects round-half-up instead of truncation.
import div_pkg::*;

module shared_divider #(
  parameter int unsigned DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
  parameter int unsigned QUOTIENT_WIDTH = DEF_QUOTIENT_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req0,
  input  logic [DIVIDEND_WIDTH-1:0] dividend0,
  input  logic [DIVIDEND_WIDTH-1:0] divisor0,
  input  logic                      req1,
  input  logic [DIVIDEND_WIDTH-1:0] dividend1,
  input  logic [DIVIDEND_WIDTH-1:0] divisor1,
  output logic                      busy,
  output logic                      done0,
  output logic                      done1,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic                      div_by_zero
);

  localparam logic [DIVIDEND_WIDTH:0] SAT_EXT =
    (DIVIDEND_WIDTH + 1)'((64'd1 << QUOTIENT_WIDTH) - 64'd1);

  state_t r_state;
  state_t w_state_next;
  logic   r_grant;
  logic   r_last_grant;
  logic   [QUOTIENT_WIDTH-1:0] r_quotient;
  logic   r_dbz;

  logic   w_load;
  logic   w_grant_sel;
  logic   w_last;
  logic   w_round_up;
  logic   w_div_zero;
  logic   [DIVIDEND_WIDTH-1:0] w_quot_core;
  logic   [DIVIDEND_WIDTH:0]   w_quot_ext;
  logic   [QUOTIENT_WIDTH-1:0] w_quot_result;

  div_core #(
    .WIDTH (DIVIDEND_WIDTH)
  ) u_core (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_load      (w_load),
    .i_dividend  (w_grant_sel ? dividend1 : dividend0),
    .i_divisor   (w_grant_sel ? divisor1  : divisor0),
    .i_step      (r_state == DIVIDE),
    .o_last      (w_last),
    .o_quot_next (w_quot_core),
    .o_round_up  (w_round_up),
    .o_div_zero  (w_div_zero)
  );

  // Result formed on the DIVIDE->DONE edge; extra bit keeps the rounding
  // carry visible to the saturation compare.
  assign w_quot_ext    = {1'b0, w_quot_core} + {{DIVIDEND_WIDTH{1'b0}}, w_round_up};
  assign w_quot_result = (w_div_zero || (w_quot_ext > SAT_EXT)) ? '1
                                                                 : w_quot_ext[QUOTIENT_WIDTH-1:0];

  // State register and result/arbitration registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_quotient   <= '0;
      r_dbz        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_grant <= w_grant_sel;
      end
      if (r_state == DONE) begin
        r_last_grant <= r_grant;
      end
      if ((r_state == DIVIDE) && w_last) begin
        r_quotient <= w_quot_result;
        r_dbz      <= w_div_zero;
      end
    end
  end

  // Next-state and grant selection.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    if (req0 && req1) begin
      w_grant_sel = ~r_last_grant;
    end else begin
      w_grant_sel = req1;
    end
    unique case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_load       = 1'b1;
          w_state_next = DIVIDE;
        end
      end
      DIVIDE: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    busy        = (r_state != IDLE);
    done0       = (r_state == DONE) && !r_grant;
    done1       = (r_state == DONE) &&  r_grant;
    quotient    = r_quotient;
    div_by_zero = r_dbz;
  end

endmodule

// File: tb/tb_shared_divider.sv
module tb_shared_divider;

  localparam int unsigned DW = 16;
  localparam int unsigned QW = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [DW-1:0] dividend0, divisor0, dividend1, divisor1;
  logic          busy, done0, done1, div_by_zero;
  logic [QW-1:0] quotient;

  int   total = 0;
  int   bad   = 0;
  int   done1_pulses = 0;
  logic both_seen = 1'b0;

  shared_divider #(
    .DIVIDEND_WIDTH (DW),
    .QUOTIENT_WIDTH (QW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req0        (req0),
    .dividend0   (dividend0),
    .divisor0    (divisor0),
    .req1        (req1),
    .dividend1   (dividend1),
    .divisor1    (divisor1),
    .busy        (busy),
    .done0       (done0),
    .done1       (done1),
    .quotient    (quotient),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (done1) done1_pulses++;
    if (done0 && done1) both_seen = 1'b1;
  end

  // Reference: plain integer division, optional round half up, clamp.
  function automatic void model(input int unsigned a, input int unsigned b,
                                output logic [QW-1:0] q, output logic dz);
    longint unsigned r;
    if (b == 0) begin
      q  = '1;
      dz = 1'b1;
      return;
    end
`ifdef DIVIDER_ROUND_EN
    r = (2 * longint'(a) + b) / (2 * longint'(b));
`else
    r = longint'(a) / b;
`endif
    if (r > ((64'd1 << QW) - 1)) r = (64'd1 << QW) - 1;
    q  = r[QW-1:0];
    dz = 1'b0;
  endfunction

  // Waits (bounded) for either done; port = -1 on timeout.
  task automatic wait_any(input int max_cyc, output int port, output int cyc);
    port = -1;
    cyc  = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clock);
      if (done0) begin port = 0; cyc = k; break; end
      if (done1) begin port = 1; cyc = k; break; end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
    repeat (3) @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done0 !== 1'b0 || done1 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b%b want=00", done0, done1); end
    total++; if (quotient !== '0) begin bad++; $display("FAIL reset_quotient got=%0d want=0", quotient); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    reset = 1'b0;
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    int p, c, d1_before;
    logic [QW-1:0] eq; logic edz;
    d1_before = done1_pulses;
    model(36000, 100, eq, edz);
    req0 = 1'b1; dividend0 = 16'd36000; divisor0 = 16'd100;
    @(negedge clock);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
    wait_any(40, p, c);
    req0 = 1'b0;
    total++; if (p !== 0 || c + 1 !== 17) begin bad++; $display("FAIL basic_latency got=port%0d/%0d want=port0/17", p, c + 1); end
    total++; if (quotient !== eq) begin bad++; $display("FAIL basic_quotient got=%0d want=%0d", quotient, eq); end
    total++; if (div_by_zero !== edz) begin bad++; $display("FAIL basic_dbz got=%b want=%b", div_by_zero, edz); end
    @(negedge clock);
    total++; if (quotient !== eq || done0 !== 1'b0) begin bad++; $display("FAIL basic_hold got=%0d/%b want=%0d/0", quotient, done0, eq); end
    total++; if (done1_pulses !== d1_before) begin bad++; $display("FAIL basic_no_done1 got=%0d want=%0d", done1_pulses, d1_before); end
  endtask

  task automatic test_div_zero();
    int p, c;
    logic [QW-1:0] eq; logic edz;
    model(1234, 0, eq, edz);
    req1 = 1'b1; dividend1 = 16'd1234; divisor1 = 16'd0;
    wait_any(40, p, c);
    req1 = 1'b0;
    total++; if (p !== 1 || c !== 17) begin bad++; $display("FAIL dz_latency got=port%0d/%0d want=port1/17", p, c); end
    total++; if (quotient !== eq || div_by_zero !== edz) begin bad++; $display("FAIL dz_result got=%h/%b want=%h/%b", quotient, div_by_zero, eq, edz); end
    @(negedge clock);
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_hold got=%b want=1", div_by_zero); end
  endtask

  // Operand pairs: saturation, rounding boundary, round-then-saturate.
  task automatic test_saturate_round();
    int unsigned av[3] = '{65535, 7, 8191};
    int unsigned bv[3] = '{1, 2, 2};
    int p, c;
    logic [QW-1:0] eq; logic edz;
    for (int i = 0; i < 3; i++) begin
      model(av[i], bv[i], eq, edz);
      req0 = 1'b1; dividend0 = DW'(av[i]); divisor0 = DW'(bv[i]);
      wait_any(40, p, c);
      req0 = 1'b0;
      total++;
      if (p !== 0 || quotient !== eq || div_by_zero !== edz) begin
        bad++;
        $display("FAIL satrnd_%0d got=port%0d q=%h dz=%b want=port0 q=%h dz=%b", i, p, quotient, div_by_zero, eq, edz);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_tie();
    int p, c;
    apply_reset();
    req0 = 1'b1; dividend0 = 16'd1000; divisor0 = 16'd10;
    req1 = 1'b1; dividend1 = 16'd5000; divisor1 = 16'd50;
    wait_any(40, p, c);
    req0 = 1'b0;
    total++; if (p !== 0 || c !== 17) begin bad++; $display("FAIL tie_first got=port%0d/%0d want=port0/17", p, c); end
    total++; if (quotient !== 12'd100) begin bad++; $display("FAIL tie_q0 got=%0d want=100", quotient); end
    wait_any(40, p, c);
    req1 = 1'b0;
    total++; if (p !== 1 || c !== 18) begin bad++; $display("FAIL tie_second got=port%0d/%0d want=port1/18", p, c); end
    total++; if (quotient !== 12'd100) begin bad++; $display("FAIL tie_q1 got=%0d want=100", quotient); end
    @(negedge clock);
    req0 = 1'b1; dividend0 = 16'd900; divisor0 = 16'd3;
    req1 = 1'b1; dividend1 = 16'd900; divisor1 = 16'd9;
    wait_any(40, p, c);
    req0 = 1'b0;
    total++; if (p !== 0 || quotient !== 12'd300) begin bad++; $display("FAIL tie_next got=port%0d q=%0d want=port0 q=300", p, quotient); end
    wait_any(40, p, c);
    req1 = 1'b0;
    total++; if (p !== 1 || quotient !== 12'd100) begin bad++; $display("FAIL tie_next2 got=port%0d q=%0d want=port1 q=100", p, quotient); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int p, c;
    req0 = 1'b1; dividend0 = 16'd4000; divisor0 = 16'd8;
    wait_any(40, p, c);
    req0 = 1'b0;
    total++; if (p !== 0 || quotient !== 12'd500) begin bad++; $display("FAIL b2b_first got=port%0d q=%0d want=port0 q=500", p, quotient); end
    req1 = 1'b1; dividend1 = 16'd300; divisor1 = 16'd7;
    wait_any(40, p, c);
    req1 = 1'b0;
    total++; if (p !== 1 || c !== 18) begin bad++; $display("FAIL b2b_second got=port%0d/%0d want=port1/18", p, c); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int p, c;
    logic [QW-1:0] eq; logic edz;
    req0 = 1'b1; dividend0 = 16'd5000; divisor0 = 16'd7;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clock);
    total++; if (busy !== 1'b0 || quotient !== '0 || done0 !== 1'b0) begin bad++; $display("FAIL midreset got=busy%b q=%0d done%b want=busy0 q=0 done0", busy, quotient, done0); end
    reset = 1'b0;
    wait_any(20, p, c);
    total++; if (p !== -1) begin bad++; $display("FAIL midreset_nodone got=port%0d want=none", p); end
    model(5000, 7, eq, edz);
    req0 = 1'b1;
    wait_any(40, p, c);
    req0 = 1'b0;
    total++; if (p !== 0 || c !== 17 || quotient !== eq) begin bad++; $display("FAIL midreset_redo got=port%0d/%0d q=%0d want=port0/17 q=%0d", p, c, quotient, eq); end
    @(negedge clock);
  endtask

  task automatic test_random();
    int unsigned a[2], b[2];
    int p, c, last, first, other, mode;
    logic [QW-1:0] eq; logic edz;
    apply_reset();
    last = 1;
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < 2; k++) begin
        a[k] = $urandom_range(0, 65535);
        case ($urandom_range(0, 3))
          0:       b[k] = 0;
          1:       b[k] = $urandom_range(1, 15);
          default: b[k] = $urandom_range(1, 65535);
        endcase
      end
      dividend0 = DW'(a[0]); divisor0 = DW'(b[0]);
      dividend1 = DW'(b[1] == 0 ? a[1] : a[1]); divisor1 = DW'(b[1]);
      mode = int'($urandom_range(0, 2));
      if (mode == 2) begin
        first = (last == 0) ? 1 : 0;
        other = 1 - first;
        req0 = 1'b1; req1 = 1'b1;
      end else begin
        first = mode;
        other = -1;
        if (mode == 0) req0 = 1'b1; else req1 = 1'b1;
      end
      model(a[first], b[first], eq, edz);
      wait_any(40, p, c);
      if (first == 0) req0 = 1'b0; else req1 = 1'b0;
      total++;
      if (p !== first || c !== 17 || quotient !== eq || div_by_zero !== edz) begin
        bad++;
        $display("FAIL rand_%0d_a got=port%0d/%0d q=%h dz=%b want=port%0d/17 q=%h dz=%b", it, p, c, quotient, div_by_zero, first, eq, edz);
      end
      last = first;
      if (other >= 0) begin
        model(a[other], b[other], eq, edz);
        wait_any(40, p, c);
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if (p !== other || c !== 18 || quotient !== eq || div_by_zero !== edz) begin
          bad++;
          $display("FAIL rand_%0d_b got=port%0d/%0d q=%h dz=%b want=port%0d/18 q=%h dz=%b", it, p, c, quotient, div_by_zero, other, eq, edz);
        end
        last = other;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_exclusive();
    total++; if (both_seen !== 1'b0) begin bad++; $display("FAIL done_exclusive got=%b want=0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_saturate_round();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
